// File: rtl/cjb_nbit_const_gen_v.sv
// cjb_nbit_const_gen_v: registered selectable WIDTH-bit constant bank with load port, sequence pointer and CNVZ flags
module cjb_nbit_const_gen_v #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [1:0]       Func_Sel,
  input  logic             Mode,
  input  logic             Step,
  input  logic             Ld_En,
  input  logic [1:0]       Ld_Sel,
  input  logic [WIDTH-1:0] Ld_Data,
  output logic [WIDTH-1:0] Const_Result,
  output logic [3:0]       Const_CNVZ,
  output logic [1:0]       Seq_Ptr,
  output logic             Valid
);
  localparam logic [63:0] ALT = 64'h5555_5555_5555_5555;
  logic [WIDTH-1:0] k [4];
  logic [1:0]       idx;
  logic [WIDTH-1:0] next_result;
  assign idx = Mode ? Seq_Ptr : Func_Sel;
  // a same-cycle write to the selected register is forwarded to the output
  assign next_result = (Ld_En && Ld_Sel == idx) ? Ld_Data : k[idx];
  always_ff @(posedge Clock) begin
    if (Reset) begin
      k[0]         <= '0;
      k[1]         <= ALT[WIDTH-1:0];
      k[2]         <= ~ALT[WIDTH-1:0];
      k[3]         <= '1;
      Const_Result <= '0;
      Const_CNVZ   <= 4'b0001;
      Seq_Ptr      <= 2'd0;
      Valid        <= 1'b0;
    end else begin
      if (Ld_En) k[Ld_Sel] <= Ld_Data;
      Const_Result <= next_result;
      Const_CNVZ   <= {1'b0, next_result[WIDTH-1], 1'b0, ~|next_result};
      if (Mode && Step) Seq_Ptr <= Seq_Ptr + 2'd1;
      Valid        <= 1'b1;
    end
  end
endmodule

// File: doc/cjb_nbit_const_gen_v.md
# cjb_nbit_const_gen_v

Parametrised, registered constant generator: the N-bit successor of the 8-bit constant-output unit in the ALU. It holds four WIDTH-bit constant registers that reset to the fixed patterns (zeros, 0101…, 1010…, ones). Each register can be overwritten at run time through a load port. The block outputs the selected constant plus CNVZ flags one cycle later, either by direct select or by stepping through a wrapping sequence pointer.

## Interface
- WIDTH, 8, data width of constants and result; legal range 2..64
- Clock  in  1  rising-edge clock; all state updates on this edge
- Reset  in  1  synchronous, active-high reset
- Func_Sel  in  2  constant index used in direct mode
- Mode  in  1  0 = direct (index = Func_Sel); 1 = sequence (index = Seq_Ptr)
- Step  in  1  advance Seq_Ptr; honoured only when Mode = 1
- Ld_En  in  1  write Ld_Data into constant register Ld_Sel
- Ld_Sel  in  2  constant register to write
- Ld_Data  in  WIDTH  value to write
- Const_Result  out  WIDTH  registered selected constant
- Const_CNVZ  out  4  registered flags {C, N, V, Z}
- Seq_Ptr  out  2  current sequence pointer
- Valid  out  1  high once outputs reflect a post-reset selection

## Operation
- Constant registers K0..K3, reset defaults (bit i, 0 ≤ i < WIDTH):
  - K0 = all zeros.
  - K1 bit i = 1 when i is even (0x55 at WIDTH = 8).
  - K2 bit i = 1 when i is odd (0xAA).
  - K3 = all ones.
- Reset on the Clock edge:
  - K0..K3 return to their defaults; earlier loads are lost.
  - Const_Result = 0, Const_CNVZ = 4'b0001, Seq_Ptr = 0, Valid = 0.
  - Ld_En and Step are ignored.
- Each non-reset edge:
  - idx = Mode ? Seq_Ptr : Func_Sel, using pre-edge values.
  - If Ld_En = 1, K[Ld_Sel] <= Ld_Data.
  - Const_Result <= (Ld_En && Ld_Sel == idx) ? Ld_Data : K[idx]. The write is forwarded to the output in the same cycle.
  - Const_CNVZ <= {1'b0, next_result[WIDTH-1], 1'b0, ~|next_result}. Flags are computed from the value being registered, never from the stale output.
  - If Mode = 1 and Step = 1, Seq_Ptr <= Seq_Ptr + 1, wrapping 3 -> 0. Otherwise Seq_Ptr holds, including throughout Mode = 0.
  - Valid <= 1.
- Sequence stepping:
  - The output of a stepping cycle uses the pre-increment pointer.
  - The next cycle's output uses the new pointer.
- Mode switching:
  - Mode may change on any cycle and takes effect on that cycle's selection.
  - Seq_Ptr is not cleared on a mode change.
- C and V are constant 0.

## Timing
- Latency is 1 cycle from Func_Sel, Mode, Seq_Ptr or Ld_* to Const_Result and Const_CNVZ.
- Throughput is one selection per cycle. There is no stall or back-pressure.
- A load is visible through K[] on the next selection. It is also visible the same edge via forwarding.
- Valid:
  - Valid rises on the first non-reset edge and stays high until the next Reset.
  - Reset asserted mid-sequence drops Valid on that edge.
- Simultaneous events:
  - Ld_En with Step is legal: the write applies and the pointer advances.
  - Ld_En with Reset: reset wins.
  - Back-to-back writes to the same Ld_Sel: the last one wins.

## Test plan
- Reset release, WIDTH = 8, Mode = 0, Func_Sel stepped 0, 1, 2, 3 on consecutive cycles -> Const_Result 0x00, 0x55, 0xAA, 0xFF one cycle after each select. CNVZ is 0001, 0000, 0100, 0100. Valid is 0 during reset and 1 from the first output.
- Ld_En = 1, Ld_Sel = 2, Ld_Data = 0x80 with Func_Sel = 2 on the same cycle -> next cycle Const_Result = 0x80 (forwarded), CNVZ = 0100. Selecting 2 again later -> 0x80.
- Mode = 1, Step held high for 6 cycles from Seq_Ptr = 0 -> outputs K0, K1, K2, K3, K0, K1 and Seq_Ptr sequence 1, 2, 3, 0, 1, 2. Then Step = 0 -> pointer and output hold.
- Load K1 = 0x00 and K3 = 0x7F, then assert Reset for one cycle mid-sequence -> Const_Result = 0, CNVZ = 0001, Seq_Ptr = 0, Valid = 0. Afterwards select 1 -> 0x55 and select 3 -> 0xFF (defaults restored).
- WIDTH = 5 instance, direct select 1, 2, 3 -> 5'b10101 (N = 1), 5'b01010 (N = 0), 5'b11111 (N = 1). Z = 0 for all three.
- Mode toggled 1 -> 0 -> 1 with Seq_Ptr = 2 and Step asserted only while Mode = 0 -> Seq_Ptr stays 2. Direct-mode outputs follow Func_Sel. On return to Mode = 1 the output resumes at K2.
